fetch_sequencer: RTL and testbench

Instruction-cycle sequencer for the Mini SRC datapath. It drives the bus-enable and load strobes of the PC, MAR, Z, MDR and IR registers through the three fetch steps T0–T2. It then hands control to the execute controller and waits for its completion before fetching again. It sits between the front-panel run/step controls and the register file / ALU / memory interface, and also supports halt, single-step and memory-timeout fault handling.

---
 rtl/mini_src_ctrl_pkg.sv | 33 +++
 rtl/mem_wait_timer.sv | 41 ++++
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_ctrl_pkg.sv
// Shared control definitions for the Mini SRC fetch/execute controllers.
package mini_src_ctrl_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W_DEF       = 32;

  // Sequencer state encoding.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StT0       = 3'd1,
    StT1       = 3'd2,
    StT2       = 3'd3,
    StDispatch = 3'd4,
    StExecWait = 3'd5,
    StHalt     = 3'd6,
    StFault    = 3'd7
  } fetch_state_e;

  // Register-transfer strobes used during fetch; the execute controller drives the same bundle.
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic z_lo_out;
    logic pc_in;
    logic mem_read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
  } strobes_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Clear/enable cycle counter that flags the last cycle T1 may wait for memory.
module mem_wait_timer
  import mini_src_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] count_d, count_q;

  // Next count: clear wins, then count up, holding at the last allowed cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LastCnt)) begin
      count_d = count_q + CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High during the MEM_TIMEOUT-th wait cycle; no ready by its end means fault.
  assign timeout = (count_q == LastCnt);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: steps T0-T2, hands off to execute, handles halt/step/fault.
module fetch_sequencer
  import mini_src_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             mem_ready,
  input  logic             exec_done,
  input  logic             exec_halt,
  output logic             pc_out,
  output logic             mar_in,
  output logic             inc_pc,
  output logic             z_in,
  output logic             z_lo_out,
  output logic             pc_in,
  output logic             mem_read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             exec_start,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  fetch_state_e     state_d, state_q;
  logic [CNT_W-1:0] instr_count_d, instr_count_q;
  logic             timeout;
  strobes_t         strb;

  // T0 is the only way into T1, so clearing there resets the timer on every entry.
  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == StT0),
    .enable (state_q == StT1),
    .timeout(timeout)
  );

  // Next-state and retired-instruction counter update.
  always_comb begin
    state_d       = state_q;
    instr_count_d = instr_count_q;
    unique case (state_q)
      StIdle: begin
        if (run || step) state_d = StT0;
      end
      StT0:       state_d = StT1;
      StT1: begin
        if (mem_ready) begin
          state_d = StT2;
        end else if (timeout) begin
          state_d = StFault;
        end
      end
      StT2:       state_d = StDispatch;
      StDispatch: state_d = StExecWait;
      StExecWait: begin
        if (exec_done) begin
          if (instr_count_q != {CNT_W{1'b1}}) begin
            instr_count_d = instr_count_q + CNT_W'(1);
          end
          if (exec_halt) begin
            state_d = StHalt;
          end else if (run) begin
            state_d = StT0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHalt:     state_d = StHalt;
      StFault:    state_d = StFault;
      default:    state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    strb       = '0;
    exec_start = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    unique case (state_q)
      StIdle: ;
      StT0: begin
        strb.pc_out = 1'b1;
        strb.mar_in = 1'b1;
        strb.inc_pc = 1'b1;
        strb.z_in   = 1'b1;
        busy        = 1'b1;
      end
      StT1: begin
        // Reloading PC from Z on every wait cycle is harmless: same value each time.
        strb.z_lo_out = 1'b1;
        strb.pc_in    = 1'b1;
        strb.mem_read = 1'b1;
        strb.mdr_in   = 1'b1;
        busy          = 1'b1;
      end
      StT2: begin
        strb.mdr_out = 1'b1;
        strb.ir_in   = 1'b1;
        busy         = 1'b1;
      end
      StDispatch: begin
        exec_start = 1'b1;
        busy       = 1'b1;
      end
      StExecWait: busy   = 1'b1;
      StHalt:     halted = 1'b1;
      StFault:    fault  = 1'b1;
      default: ;
    endcase
  end

  assign pc_out      = strb.pc_out;
  assign mar_in      = strb.mar_in;
  assign inc_pc      = strb.inc_pc;
  assign z_in        = strb.z_in;
  assign z_lo_out    = strb.z_lo_out;
  assign pc_in       = strb.pc_in;
  assign mem_read    = strb.mem_read;
  assign mdr_in      = strb.mdr_in;
  assign mdr_out     = strb.mdr_out;
  assign ir_in       = strb.ir_in;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer (MEM_TIMEOUT=4, CNT_W=4) using a scoreboard queue.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, step, mem_ready, exec_done, exec_halt;
  logic       pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, mem_read, mdr_in;
  logic       mdr_out, ir_in, exec_start, busy, halted, fault;
  logic [3:0] instr_count;
  logic [13:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef enum int {EIdle, ET0, ET1, ET2, EDisp, EWait, EHalt, EFault} est_e;

  typedef struct {
    logic r; logic s; logic mr; logic d; logic h;
    est_e st;
    int   cnt;
  } cyc_t;

  typedef struct {
    logic [13:0] vec;
    logic [3:0]  cnt;
  } exp_t;

  cyc_t stim[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .mem_ready  (mem_ready),
    .exec_done  (exec_done),
    .exec_halt  (exec_halt),
    .pc_out     (pc_out),
    .mar_in     (mar_in),
    .inc_pc     (inc_pc),
    .z_in       (z_in),
    .z_lo_out   (z_lo_out),
    .pc_in      (pc_in),
    .mem_read   (mem_read),
    .mdr_in     (mdr_in),
    .mdr_out    (mdr_out),
    .ir_in      (ir_in),
    .exec_start (exec_start),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .instr_count(instr_count)
  );

  assign obs = {pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, mem_read, mdr_in,
                mdr_out, ir_in, exec_start, busy, halted, fault};

  // Expected output vector for each state: 10 strobes, exec_start, busy, halted, fault.
  function automatic logic [13:0] exp_vec(input est_e e);
    case (e)
      ET0:     return 14'b1111_0000_00_0100;
      ET1:     return 14'b0000_1111_00_0100;
      ET2:     return 14'b0000_0000_11_0100;
      EDisp:   return 14'b0000_0000_00_1100;
      EWait:   return 14'b0000_0000_00_0100;
      EHalt:   return 14'b0000_0000_00_0010;
      EFault:  return 14'b0000_0000_00_0001;
      default: return 14'b0000_0000_00_0000;
    endcase
  endfunction

  function automatic cyc_t mk(input logic r, input logic s, input logic mr, input logic d,
                              input logic h, input est_e st, input int cnt);
    cyc_t c;
    c.r = r; c.s = s; c.mr = mr; c.d = d; c.h = h; c.st = st; c.cnt = cnt;
    return c;
  endfunction

  function automatic exp_t mk_exp(input est_e st, input int cnt);
    exp_t e;
    e.vec = exp_vec(st);
    e.cnt = 4'(cnt);
    return e;
  endfunction

  task automatic clear_inputs();
    {run, step, mem_ready, exec_done, exec_halt} = 5'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clear_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b1;
    run   = 1'b1;
    step  = 1'b1;
    sb.push_back(mk_exp(EIdle, 0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests_run++;
    if (obs !== e.vec || instr_count !== e.cnt) begin
      tests_failed++;
      $display("FAIL reset_state: outputs %b count %0d, expected %b count %0d",
               obs, instr_count, e.vec, e.cnt);
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  // Runs the staged stimulus, scoreboarding one expectation per clock.
  task automatic test_fetch();
    cyc_t c;
    exp_t e;
    int   idx = 0;
    do_reset();
    stim.delete();
    stim.push_back(mk(1, 0, 0, 0, 0, ET0,   0));
    stim.push_back(mk(1, 0, 0, 0, 0, ET1,   0));
    stim.push_back(mk(1, 0, 1, 0, 0, ET2,   0));
    stim.push_back(mk(1, 0, 0, 0, 0, EDisp, 0));
    stim.push_back(mk(1, 0, 0, 0, 0, EWait, 0));
    stim.push_back(mk(1, 0, 0, 0, 0, EWait, 0));
    stim.push_back(mk(1, 0, 0, 1, 0, ET0,   1));
    stim.push_back(mk(0, 0, 0, 0, 0, ET1,   1));
    stim.push_back(mk(0, 0, 1, 0, 0, ET2,   1));
    stim.push_back(mk(0, 0, 0, 0, 0, EDisp, 1));
    stim.push_back(mk(0, 0, 0, 0, 0, EWait, 1));
    stim.push_back(mk(0, 0, 0, 1, 0, EIdle, 2));
    stim.push_back(mk(0, 0, 0, 0, 0, EIdle, 2));
    stim.push_back(mk(0, 0, 0, 1, 0, EIdle, 2));
    while (stim.size() > 0) begin
      c = stim.pop_front();
      {run, step, mem_ready, exec_done, exec_halt} = {c.r, c.s, c.mr, c.d, c.h};
      sb.push_back(mk_exp(c.st, c.cnt));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (obs !== e.vec || instr_count !== e.cnt) begin
        tests_failed++;
        $display("FAIL fetch[%0d]: outputs %b count %0d, expected %b count %0d",
                 idx, obs, instr_count, e.vec, e.cnt);
      end
      idx++;
    end
    clear_inputs();
  endtask

  task automatic test_step();
    cyc_t c;
    exp_t e;
    int   idx = 0;
    do_reset();
    stim.delete();
    stim.push_back(mk(0, 1, 0, 0, 0, ET0,   0));
    stim.push_back(mk(0, 0, 0, 0, 0, ET1,   0));
    stim.push_back(mk(0, 0, 1, 0, 0, ET2,   0));
    stim.push_back(mk(0, 0, 0, 0, 0, EDisp, 0));
    stim.push_back(mk(0, 0, 0, 0, 0, EWait, 0));
    stim.push_back(mk(0, 1, 0, 0, 0, EWait, 0));
    stim.push_back(mk(0, 0, 0, 0, 0, EWait, 0));
    stim.push_back(mk(0, 0, 0, 0, 0, EWait, 0));
    stim.push_back(mk(0, 0, 0, 1, 0, EIdle, 1));
    stim.push_back(mk(0, 0, 0, 0, 0, EIdle, 1));
    while (stim.size() > 0) begin
      c = stim.pop_front();
      {run, step, mem_ready, exec_done, exec_halt} = {c.r, c.s, c.mr, c.d, c.h};
      sb.push_back(mk_exp(c.st, c.cnt));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (obs !== e.vec || instr_count !== e.cnt) begin
        tests_failed++;
        $display("FAIL step[%0d]: outputs %b count %0d, expected %b count %0d",
                 idx, obs, instr_count, e.vec, e.cnt);
      end
      idx++;
    end
    clear_inputs();
  endtask

  task automatic test_wait_states();
    cyc_t c;
    exp_t e;
    int   idx = 0;
    int   inc_cycles = 0;
    int   t1_cycles = 0;
    do_reset();
    stim.delete();
    stim.push_back(mk(1, 0, 0, 0, 0, ET0,   0));
    stim.push_back(mk(1, 0, 0, 0, 0, ET1,   0));
    stim.push_back(mk(1, 0, 0, 0, 0, ET1,   0));
    stim.push_back(mk(0, 0, 0, 0, 0, ET1,   0));
    stim.push_back(mk(0, 0, 0, 0, 0, ET1,   0));
    stim.push_back(mk(0, 0, 1, 0, 0, ET2,   0));
    stim.push_back(mk(0, 0, 0, 0, 0, EDisp, 0));
    stim.push_back(mk(0, 0, 0, 0, 0, EWait, 0));
    stim.push_back(mk(0, 0, 0, 1, 0, EIdle, 1));
    while (stim.size() > 0) begin
      c = stim.pop_front();
      {run, step, mem_ready, exec_done, exec_halt} = {c.r, c.s, c.mr, c.d, c.h};
      sb.push_back(mk_exp(c.st, c.cnt));
      @(posedge clk);
      #1;
      inc_cycles += int'(inc_pc);
      t1_cycles  += int'(mem_read);
      e = sb.pop_front();
      tests_run++;
      if (obs !== e.vec || instr_count !== e.cnt) begin
        tests_failed++;
        $display("FAIL wait_states[%0d]: outputs %b count %0d, expected %b count %0d",
                 idx, obs, instr_count, e.vec, e.cnt);
      end
      idx++;
    end
    tests_run++;
    if (inc_cycles != 1 || t1_cycles != 4) begin
      tests_failed++;
      $display("FAIL wait_states_len: inc_pc cycles %0d, T1 cycles %0d, expected 1 and 4",
               inc_cycles, t1_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    cyc_t c;
    exp_t e;
    int   idx = 0;
    int   rd_cycles = 0;
    do_reset();
    stim.delete();
    stim.push_back(mk(1, 0, 0, 0, 0, ET0,    0));
    stim.push_back(mk(0, 0, 0, 0, 0, ET1,    0));
    stim.push_back(mk(0, 0, 0, 0, 0, ET1,    0));
    stim.push_back(mk(0, 0, 0, 0, 0, ET1,    0));
    stim.push_back(mk(0, 0, 0, 0, 0, ET1,    0));
    stim.push_back(mk(0, 0, 0, 0, 0, EFault, 0));
    stim.push_back(mk(1, 0, 1, 0, 0, EFault, 0));
    stim.push_back(mk(0, 1, 1, 1, 0, EFault, 0));
    stim.push_back(mk(1, 1, 0, 1, 1, EFault, 0));
    while (stim.size() > 0) begin
      c = stim.pop_front();
      {run, step, mem_ready, exec_done, exec_halt} = {c.r, c.s, c.mr, c.d, c.h};
      sb.push_back(mk_exp(c.st, c.cnt));
      @(posedge clk);
      #1;
      rd_cycles += int'(mem_read);
      e = sb.pop_front();
      tests_run++;
      if (obs !== e.vec || instr_count !== e.cnt) begin
        tests_failed++;
        $display("FAIL timeout[%0d]: outputs %b count %0d, expected %b count %0d",
                 idx, obs, instr_count, e.vec, e.cnt);
      end
      idx++;
    end
    tests_run++;
    if (rd_cycles != 4) begin
      tests_failed++;
      $display("FAIL timeout_len: mem_read cycles %0d, expected 4", rd_cycles);
    end
    // Only reset leaves FAULT.
    clear_inputs();
    reset = 1'b1;
    #1;
    tests_run++;
    if (fault !== 1'b0 || obs !== 14'b0) begin
      tests_failed++;
      $display("FAIL fault_reset: outputs %b, expected %b", obs, 14'b0);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_halt();
    cyc_t c;
    exp_t e;
    int   idx = 0;
    do_reset();
    stim.delete();
    stim.push_back(mk(1, 0, 0, 0, 0, ET0,   0));
    stim.push_back(mk(1, 0, 1, 0, 0, ET1,   0));
    stim.push_back(mk(1, 0, 1, 0, 0, ET2,   0));
    stim.push_back(mk(1, 0, 0, 0, 0, EDisp, 0));
    stim.push_back(mk(1, 0, 0, 0, 0, EWait, 0));
    stim.push_back(mk(1, 0, 0, 1, 1, EHalt, 1));
    stim.push_back(mk(1, 0, 1, 0, 0, EHalt, 1));
    stim.push_back(mk(1, 1, 1, 1, 0, EHalt, 1));
    stim.push_back(mk(1, 0, 0, 0, 0, EHalt, 1));
    while (stim.size() > 0) begin
      c = stim.pop_front();
      {run, step, mem_ready, exec_done, exec_halt} = {c.r, c.s, c.mr, c.d, c.h};
      sb.push_back(mk_exp(c.st, c.cnt));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (obs !== e.vec || instr_count !== e.cnt) begin
        tests_failed++;
        $display("FAIL halt[%0d]: outputs %b count %0d, expected %b count %0d",
                 idx, obs, instr_count, e.vec, e.cnt);
      end
      idx++;
    end
    clear_inputs();
  endtask

  // 17 back-to-back instructions saturate the 4-bit counter, then reset hits mid-T1.
  task automatic test_saturation();
    cyc_t c;
    exp_t e;
    int   idx = 0;
    int   cb;
    do_reset();
    stim.delete();
    stim.push_back(mk(1, 0, 1, 0, 0, ET0, 0));
    for (int i = 0; i < 17; i++) begin
      cb = (i > 15) ? 15 : i;
      stim.push_back(mk(1, 0, 1, 0, 0, ET1,   cb));
      stim.push_back(mk(1, 0, 1, 0, 0, ET2,   cb));
      stim.push_back(mk(1, 0, 1, 0, 0, EDisp, cb));
      stim.push_back(mk(1, 0, 1, 0, 0, EWait, cb));
      stim.push_back(mk(1, 0, 1, 1, 0, ET0,   ((i + 1) > 15) ? 15 : (i + 1)));
    end
    stim.push_back(mk(0, 0, 0, 0, 0, ET1, 15));
    while (stim.size() > 0) begin
      c = stim.pop_front();
      {run, step, mem_ready, exec_done, exec_halt} = {c.r, c.s, c.mr, c.d, c.h};
      sb.push_back(mk_exp(c.st, c.cnt));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (obs !== e.vec || instr_count !== e.cnt) begin
        tests_failed++;
        $display("FAIL saturation[%0d]: outputs %b count %0d, expected %b count %0d",
                 idx, obs, instr_count, e.vec, e.cnt);
      end
      idx++;
    end
    // Asynchronous reset mid-T1: no clock edge between assertion and check.
    clear_inputs();
    #1;
    reset = 1'b1;
    sb.push_back(mk_exp(EIdle, 0));
    #1;
    e = sb.pop_front();
    tests_run++;
    if (obs !== e.vec || instr_count !== e.cnt || mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: outputs %b count %0d, expected %b count %0d",
               obs, instr_count, e.vec, e.cnt);
    end
    #1;
    reset = 1'b0;
    // No fresh run/step: must stay idle.
    sb.push_back(mk_exp(EIdle, 0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests_run++;
    if (obs !== e.vec || instr_count !== e.cnt) begin
      tests_failed++;
      $display("FAIL post_reset_idle: outputs %b count %0d, expected %b count %0d",
               obs, instr_count, e.vec, e.cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_step();
    test_wait_states();
    test_timeout();
    test_halt();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
